// File: rtl/lcd_pkg.sv
// Shared constants, FSM encoding and BCD helpers for the LCD temperature
// formatter and its binary-to-BCD engine.
package lcd_pkg;

    localparam logic [7:0] LCD_CMD_HOME = 8'h80;
    localparam logic [7:0] ASCII_T      = 8'h54;
    localparam logic [7:0] ASCII_EQ     = 8'h3D;
    localparam logic [7:0] ASCII_0      = 8'h30;
    localparam logic [7:0] ASCII_SP     = 8'h20;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        EMIT = 2'd2
    } state_t;

    // One shift-add-3 iteration on {bcd[11:0], bin[7:0]}.
    function automatic logic [19:0] bcd_step(input logic [19:0] sr);
        logic [19:0] a;
        a = sr;
        for (int n = 0; n < 3; n++) begin
            if (a[8+4*n +: 4] >= 4'd5)
                a[8+4*n +: 4] = a[8+4*n +: 4] + 4'd3;
        end
        return {a[18:0], 1'b0};
    endfunction

    function automatic logic [7:0] digit_char(input logic [3:0] d);
        return ASCII_0 + {4'd0, d};
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Iterative 8-bit binary to 3-digit BCD converter, one bit per cycle.
// Ports: clk, rst (async active-low), start/bin in; done pulse, bcd {H,T,U} out.
module bin2bcd_seq
    import lcd_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [7:0]  bin,
    output logic        done,
    output logic [11:0] bcd
);

    logic [19:0] sr;
    logic [2:0]  cnt;
    logic        running;

    assign bcd = sr[19:8];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sr      <= '0;
            cnt     <= '0;
            running <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                sr      <= {12'd0, bin};
                cnt     <= '0;
                running <= 1'b1;
            end else if (running) begin
                sr  <= bcd_step(sr);
                cnt <= cnt + 3'd1;
                if (cnt == 3'd7) begin
                    running <= 1'b0;
                    done    <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/lcd_temp_formatter.sv
// Captures a temperature sample, converts it to BCD and streams the
// 8-byte LCD frame: home cmd, 'T', '=', H, T, U, degree glyph, unit letter.
// Ports: clk, rst (async active-low), temp_value/temp_valid in;
//        char_data/char_rs/char_valid out, char_ready in; busy, frame_done out.
module lcd_temp_formatter
    import lcd_pkg::*;
#(
    parameter logic [7:0] DEG_CHAR   = 8'hDF,
    parameter logic [7:0] UNIT_CHAR  = 8'h43,
    parameter bit         LEAD_BLANK = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] temp_value,
    input  logic       temp_valid,
    output logic [7:0] char_data,
    output logic       char_rs,
    output logic       char_valid,
    input  logic       char_ready,
    output logic       busy,
    output logic       frame_done
);

    state_t      state;
    logic [2:0]  idx;
    logic [2:0]  nidx;
    logic [3:0]  hund;
    logic [3:0]  tens;
    logic [3:0]  units;
    logic        pend_valid;
    logic [7:0]  pend_val;

    logic        accept;
    logic        last_accept;
    logic        start;
    logic [7:0]  start_val;
    logic        eng_done;
    logic [11:0] eng_bcd;
    logic        blank_h;
    logic        blank_t;
    logic [7:0]  next_byte;

    assign accept      = char_valid & char_ready;
    assign last_accept = (state == EMIT) && accept && (idx == 3'd7);
    assign nidx        = idx + 3'd1;

    // The engine starts either on a fresh strobe in IDLE or straight out
    // of a finished frame; a strobe on the final accept beats the stored one.
    always_comb begin
        start     = 1'b0;
        start_val = temp_value;
        if (state == IDLE && temp_valid) begin
            start = 1'b1;
        end else if (last_accept && (temp_valid || pend_valid)) begin
            start     = 1'b1;
            start_val = temp_valid ? temp_value : pend_val;
        end
    end

    bin2bcd_seq u_bcd (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .bin   (start_val),
        .done  (eng_done),
        .bcd   (eng_bcd)
    );

    assign blank_h = LEAD_BLANK && (hund == 4'd0);
    assign blank_t = blank_h && (tens == 4'd0);

    // Byte for the slot after the current one, loaded on accept.
    always_comb begin
        next_byte = UNIT_CHAR;
        unique case (nidx)
            3'd0: next_byte = LCD_CMD_HOME;
            3'd1: next_byte = ASCII_T;
            3'd2: next_byte = ASCII_EQ;
            3'd3: next_byte = blank_h ? ASCII_SP : digit_char(hund);
            3'd4: next_byte = blank_t ? ASCII_SP : digit_char(tens);
            3'd5: next_byte = digit_char(units);
            3'd6: next_byte = DEG_CHAR;
            3'd7: next_byte = UNIT_CHAR;
            default: next_byte = UNIT_CHAR;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            idx        <= '0;
            hund       <= '0;
            tens       <= '0;
            units      <= '0;
            pend_valid <= 1'b0;
            pend_val   <= '0;
            char_data  <= '0;
            char_rs    <= 1'b0;
            char_valid <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;

            // Strobes arriving while busy land in the 1-deep pending slot.
            if (temp_valid && state != IDLE && !last_accept) begin
                pend_valid <= 1'b1;
                pend_val   <= temp_value;
            end

            unique case (state)
                IDLE: begin
                    if (temp_valid) begin
                        busy  <= 1'b1;
                        state <= CONV;
                    end
                end
                CONV: begin
                    if (eng_done) begin
                        state      <= EMIT;
                        idx        <= '0;
                        hund       <= eng_bcd[11:8];
                        tens       <= eng_bcd[7:4];
                        units      <= eng_bcd[3:0];
                        char_data  <= LCD_CMD_HOME;
                        char_rs    <= 1'b0;
                        char_valid <= 1'b1;
                    end
                end
                EMIT: begin
                    if (accept) begin
                        if (idx == 3'd7) begin
                            char_valid <= 1'b0;
                            frame_done <= 1'b1;
                            if (start) begin
                                state      <= CONV;
                                pend_valid <= 1'b0;
                            end else begin
                                state <= IDLE;
                                busy  <= 1'b0;
                            end
                        end else begin
                            idx       <= nidx;
                            char_data <= next_byte;
                            char_rs   <= 1'b1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lcd_temp_formatter.sv
// Directed bench for lcd_temp_formatter: frame content, latency,
// backpressure, pending strobes, mid-frame reset and parameter overrides.
module tb_lcd_temp_formatter;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] temp_value = 8'd0;
    logic       temp_valid = 1'b0;
    logic       char_ready = 1'b1;

    logic [7:0] cd0, cd1;
    logic       rs0, rs1, cv0, cv1, bz0, bz1, fd0, fd1;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    lcd_temp_formatter dut0 (
        .clk        (clk),
        .rst        (rst),
        .temp_value (temp_value),
        .temp_valid (temp_valid),
        .char_data  (cd0),
        .char_rs    (rs0),
        .char_valid (cv0),
        .char_ready (char_ready),
        .busy       (bz0),
        .frame_done (fd0)
    );

    lcd_temp_formatter #(
        .DEG_CHAR   (8'h2A),
        .UNIT_CHAR  (8'h43),
        .LEAD_BLANK (1'b0)
    ) dut1 (
        .clk        (clk),
        .rst        (rst),
        .temp_value (temp_value),
        .temp_valid (temp_valid),
        .char_data  (cd1),
        .char_rs    (rs1),
        .char_valid (cv1),
        .char_ready (char_ready),
        .busy       (bz1),
        .frame_done (fd1)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] data_of(input int s);
        return (s != 0) ? cd1 : cd0;
    endfunction
    function automatic logic rs_of(input int s);
        return (s != 0) ? rs1 : rs0;
    endfunction
    function automatic logic vld_of(input int s);
        return (s != 0) ? cv1 : cv0;
    endfunction
    function automatic logic busy_of(input int s);
        return (s != 0) ? bz1 : bz0;
    endfunction
    function automatic logic done_of(input int s);
        return (s != 0) ? fd1 : fd0;
    endfunction

    task automatic strobe(input logic [7:0] v);
        @(negedge clk);
        temp_value = v;
        temp_valid = 1'b1;
        @(posedge clk);
        #1;
        temp_valid = 1'b0;
    endtask

    task automatic wait_valid(input int s);
        int k;
        k = 0;
        while (!vld_of(s) && k < 20) begin
            @(posedge clk);
            #1;
            k++;
            if (k == 1) chk("busy_conv", {31'd0, busy_of(s)}, 1);
        end
        chk("latency", k, 9);
    endtask

    task automatic read_frame(input int s, input logic [7:0] h,
                              input logic [7:0] t, input logic [7:0] u,
                              input logic [7:0] deg, input bit inject);
        logic [7:0] e [8];
        e = '{8'h80, 8'h54, 8'h3D, h, t, u, deg, 8'h43};
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("byte%0d", i), {24'd0, data_of(s)}, {24'd0, e[i]});
            chk($sformatf("rs%0d", i), {31'd0, rs_of(s)}, (i == 0) ? 0 : 1);
            chk($sformatf("vld%0d", i), {31'd0, vld_of(s)}, 1);
            if (inject && i == 1) begin
                temp_value = 8'd40;
                temp_valid = 1'b1;
            end else if (inject && i == 2) begin
                temp_value = 8'd77;
                temp_valid = 1'b1;
            end else begin
                temp_valid = 1'b0;
            end
            @(posedge clk);
            #1;
        end
        temp_valid = 1'b0;
        chk("frame_done", {31'd0, done_of(s)}, 1);
        chk("valid_off", {31'd0, vld_of(s)}, 0);
    endtask

    task automatic expect_frame(input int s, input logic [7:0] v,
                                input logic [7:0] h, input logic [7:0] t,
                                input logic [7:0] u, input logic [7:0] deg);
        strobe(v);
        wait_valid(s);
        read_frame(s, h, t, u, deg, 1'b0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [7:0] tail [4];
        bit seen;

        rst        = 1'b0;
        char_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", {31'd0, cv0}, 0);
        chk("rst_data",  {24'd0, cd0}, 0);
        chk("rst_rs",    {31'd0, rs0}, 0);
        chk("rst_busy",  {31'd0, bz0}, 0);
        chk("rst_done",  {31'd0, fd0}, 0);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // T1 / T2: frame content and leading blanks
        expect_frame(0, 8'd25,  8'h20, 8'h32, 8'h35, 8'hDF);
        chk("busy_idle", {31'd0, bz0}, 0);
        expect_frame(0, 8'd255, 8'h32, 8'h35, 8'h35, 8'hDF);
        expect_frame(0, 8'd0,   8'h20, 8'h20, 8'h30, 8'hDF);
        expect_frame(0, 8'd105, 8'h31, 8'h30, 8'h35, 8'hDF);

        // T3: stall at the hundreds digit
        strobe(8'd123);
        wait_valid(0);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        chk("pre_stall", {24'd0, cd0}, 32'h31);
        char_ready = 1'b0;
        for (int j = 0; j < 5; j++) begin
            @(posedge clk);
            #1;
            chk("stall_data",  {24'd0, cd0}, 32'h31);
            chk("stall_valid", {31'd0, cv0}, 1);
        end
        char_ready = 1'b1;
        tail = '{8'h32, 8'h33, 8'hDF, 8'h43};
        for (int j = 0; j < 4; j++) begin
            @(posedge clk);
            #1;
            chk($sformatf("tail%0d", j), {24'd0, cd0}, {24'd0, tail[j]});
        end
        @(posedge clk);
        #1;
        chk("stall_done", {31'd0, fd0}, 1);

        // T4: two strobes during a frame, only the newest survives
        repeat (2) @(posedge clk);
        #1;
        strobe(8'd25);
        wait_valid(0);
        read_frame(0, 8'h20, 8'h32, 8'h35, 8'hDF, 1'b1);
        chk("busy_hold", {31'd0, bz0}, 1);
        wait_valid(0);
        read_frame(0, 8'h20, 8'h37, 8'h37, 8'hDF, 1'b0);
        seen = 1'b0;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (cv0) seen = 1'b1;
        end
        chk("no_third_frame", {31'd0, seen}, 0);
        chk("busy_after", {31'd0, bz0}, 0);

        // T5: reset in the middle of a frame
        strobe(8'd25);
        wait_valid(0);
        repeat (5) begin
            @(posedge clk);
            #1;
        end
        chk("pre_rst", {24'd0, cd0}, 32'h35);
        #2;
        rst = 1'b0;
        #1;
        chk("arst_valid", {31'd0, cv0}, 0);
        chk("arst_data",  {24'd0, cd0}, 0);
        chk("arst_rs",    {31'd0, rs0}, 0);
        chk("arst_busy",  {31'd0, bz0}, 0);
        chk("arst_done",  {31'd0, fd0}, 0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        seen = 1'b0;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (cv0 || bz0) seen = 1'b1;
        end
        chk("post_rst_quiet", {31'd0, seen}, 0);

        // T6: overridden glyph and no leading blanks, then default instance
        expect_frame(1, 8'd7, 8'h30, 8'h30, 8'h37, 8'h2A);
        expect_frame(0, 8'd7, 8'h20, 8'h20, 8'h37, 8'hDF);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
